// File: rtl/urv_div_sched_pkg.sv
// Shared definitions for the execute-stage divider scheduler.
// Function codes, FSM encoding and special-case result constants.
package urv_div_sched_pkg;

  localparam logic [2:0] FUNC_DIV  = 3'd4;
  localparam logic [2:0] FUNC_DIVU = 3'd5;
  localparam logic [2:0] FUNC_REM  = 3'd6;
  localparam logic [2:0] FUNC_REMU = 3'd7;

  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/urv_div_result_cache.sv
// Single-entry quotient/remainder cache keyed on operands and signedness.
// A hit returns q or r so DIV/REM pairs share one divider run.
module urv_div_result_cache (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_i,
  input  logic        inv_i,
  input  logic [31:0] wr_rs1_i,
  input  logic [31:0] wr_rs2_i,
  input  logic        wr_signed_i,
  input  logic [31:0] wr_q_i,
  input  logic [31:0] wr_r_i,
  input  logic [31:0] rd_rs1_i,
  input  logic [31:0] rd_rs2_i,
  input  logic        rd_signed_i,
  input  logic        rd_rem_i,
  output logic        hit_o,
  output logic [31:0] data_o
);

  logic        vld_q;
  logic        sgn_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic [31:0] q_q;
  logic [31:0] r_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_q <= 1'b0;
      sgn_q <= 1'b0;
      rs1_q <= '0;
      rs2_q <= '0;
      q_q   <= '0;
      r_q   <= '0;
    end else if (inv_i) begin
      vld_q <= 1'b0;
    end else if (wr_i) begin
      vld_q <= 1'b1;
      sgn_q <= wr_signed_i;
      rs1_q <= wr_rs1_i;
      rs2_q <= wr_rs2_i;
      q_q   <= wr_q_i;
      r_q   <= wr_r_i;
    end
  end

  assign hit_o = vld_q
              && (rs1_q == rd_rs1_i)
              && (rs2_q == rd_rs2_i)
              && (sgn_q == rd_signed_i);

  assign data_o = rd_rem_i ? r_q : q_q;

endmodule

// File: rtl/urv_div_sched.sv
// Execute-stage controller for the shared iterative divider.
// Define URV_DIV_FASTPATH_EN to resolve div-by-zero/overflow in IDLE.
module urv_div_sched
  import urv_div_sched_pkg::*;
#(
  parameter int DIV_TIMEOUT = 63
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_valid_i,
  input  logic        x_is_divide_i,
  input  logic [2:0]  x_fun_i,
  input  logic [31:0] x_rs1_i,
  input  logic [31:0] x_rs2_i,
  input  logic        x_stall_i,
  input  logic        x_kill_i,
  output logic        x_stall_req_o,
  output logic [31:0] x_rd_o,
  output logic        x_rd_valid_o,
  output logic        div_start_o,
  output logic        div_abort_o,
  output logic        div_signed_o,
  output logic [31:0] div_rs1_o,
  output logic [31:0] div_rs2_o,
  input  logic        div_done_i,
  input  logic [31:0] div_q_i,
  input  logic [31:0] div_r_i
);

  localparam logic [15:0] TLIM = 16'(DIV_TIMEOUT - 1);

  state_e      state_q;
  state_e      state_d;
  logic        req;
  logic        sgn;
  logic        rem;
  logic        hit;
  logic [31:0] hit_data;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic        sgn_q;
  logic        rem_q;
  logic [31:0] rd_d;
  logic        rd_ld;
  logic        lat;
  logic        c_wr;
  logic [15:0] cnt_q;
  logic        tmo;
  logic        fast;
  logic [31:0] fast_val;
  logic        unused_fun;

  assign req = x_valid_i & x_is_divide_i & ~x_kill_i;
  assign sgn = ~x_fun_i[0];
  assign rem = x_fun_i[1];
  assign unused_fun = x_fun_i[2];

`ifdef URV_DIV_FASTPATH_EN
  logic fz;
  logic fo;

  assign fz   = (x_rs2_i == '0);
  assign fo   = sgn && (x_rs1_i == INT_MIN) && (x_rs2_i == ALL_ONES);
  assign fast = fz | fo;

  always_comb begin
    fast_val = '0;
    if (fz) fast_val = rem ? x_rs1_i : ALL_ONES;
    else    fast_val = rem ? '0 : INT_MIN;
  end
`else
  assign fast     = 1'b0;
  assign fast_val = '0;
`endif

  // Done in the expiry cycle wins over the watchdog.
  assign tmo = (DIV_TIMEOUT != 0)
            && (state_q == S_WAIT)
            && (cnt_q == TLIM)
            && !div_done_i;

  urv_div_result_cache u_cache (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .wr_i        (c_wr),
    .inv_i       (1'b0),
    .wr_rs1_i    (rs1_q),
    .wr_rs2_i    (rs2_q),
    .wr_signed_i (sgn_q),
    .wr_q_i      (div_q_i),
    .wr_r_i      (div_r_i),
    .rd_rs1_i    (x_rs1_i),
    .rd_rs2_i    (x_rs2_i),
    .rd_signed_i (sgn),
    .rd_rem_i    (rem),
    .hit_o       (hit),
    .data_o      (hit_data)
  );

  always_comb begin
    state_d       = state_q;
    rd_d          = x_rd_o;
    rd_ld         = 1'b0;
    lat           = 1'b0;
    c_wr          = 1'b0;
    x_stall_req_o = 1'b0;
    x_rd_valid_o  = 1'b0;
    div_start_o   = 1'b0;
    div_abort_o   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        x_stall_req_o = req;
        if (req) begin
          if (fast) begin
            state_d = S_RESP;
            rd_d    = fast_val;
            rd_ld   = 1'b1;
          end else if (hit) begin
            state_d = S_RESP;
            rd_d    = hit_data;
            rd_ld   = 1'b1;
          end else begin
            state_d = S_ISSUE;
            lat     = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        x_stall_req_o = 1'b1;
        if (x_kill_i) begin
          div_abort_o = 1'b1;
          state_d     = S_IDLE;
        end else begin
          div_start_o = 1'b1;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        x_stall_req_o = 1'b1;
        if (x_kill_i) begin
          div_abort_o = 1'b1;
          state_d     = S_IDLE;
        end else if (div_done_i) begin
          rd_d    = rem_q ? div_r_i : div_q_i;
          rd_ld   = 1'b1;
          c_wr    = 1'b1;
          state_d = S_RESP;
        end else if (tmo) begin
          div_abort_o = 1'b1;
          rd_d        = '0;
          rd_ld       = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        x_rd_valid_o = 1'b1;
        if (x_kill_i || !x_stall_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      sgn_q   <= 1'b0;
      rem_q   <= 1'b0;
      x_rd_o  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (lat) begin
        rs1_q <= x_rs1_i;
        rs2_q <= x_rs2_i;
        sgn_q <= sgn;
        rem_q <= rem;
      end
      if (rd_ld) x_rd_o <= rd_d;
      if (state_q == S_ISSUE)     cnt_q <= '0;
      else if (state_q == S_WAIT) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign div_signed_o = sgn_q;
  assign div_rs1_o    = rs1_q;
  assign div_rs2_o    = rs2_q;

endmodule
